// File: rtl/next_pc_gen.sv
//----------------------------------------------------------------------------
// next_pc_gen
// Next-PC generator: selects the value the PC register loads on the next
// edge (stall / RET / BL / B / B.cond / sequential) and maintains a small
// circular return-address stack for BL/RET pairs.
// Optional feature: define NEXT_PC_TRACE_EN to print control-flow trace
// and RAS overflow/underflow warnings in simulation.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module next_pc_gen #(
  parameter int                 WIDTH    = 64,
  parameter int                 DEPTH    = 4,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          count,
  input  logic                      stall,
  input  logic                      cond_br,
  input  logic                      cond_true,
  input  logic                      uncond_br,
  input  logic                      link,
  input  logic                      ret,
  input  logic [WIDTH-1:0]          br_offset,
  input  logic [WIDTH-1:0]          reg_target,
  output logic [WIDTH-1:0]          PCinput,
  output logic [$clog2(DEPTH):0]    ras_depth,
  output logic                      ras_overflow,
  output logic                      ras_underflow
);

  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam int                 DW      = PTR_W + 1;
  localparam logic [DW-1:0]      FULL    = DW'(DEPTH);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [DW-1:0]    depth;
  logic             ovf;
  logic             unf;

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] ras_top;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] prev_ptr;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;

  assign seq      = count + WIDTH'(4);
  assign target   = count + (br_offset << 2);
  assign ras_top  = stack[top_ptr];
  assign next_ptr = top_ptr + PTR_W'(1);
  assign prev_ptr = top_ptr - PTR_W'(1);
  assign full     = (depth == FULL);
  assign empty    = (depth == '0);

  // RAS operation decode; a stall suppresses every state change
  assign do_push  = !stall && link && !ret;
  assign do_pop   = !stall && ret && !link;
  assign do_swap  = !stall && ret && link;

  assign ras_depth     = depth;
  assign ras_overflow  = ovf;
  assign ras_underflow = unf;

  // Next-PC priority mux: reset, stall, RET, BL/B, taken B.cond, sequential
  always_comb begin
    PCinput = seq;
    if (!rst)                       PCinput = RESET_PC;
    else if (stall)                 PCinput = count;
    else if (ret)                   PCinput = empty ? reg_target : ras_top;
    else if (link || uncond_br)     PCinput = target;
    else if (cond_br && cond_true)  PCinput = target;
  end

  // Stack pointer, occupancy and sticky flags; a full push wraps onto the oldest entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      top_ptr <= '0;
      depth   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
    end else begin
      if (do_push) begin
        top_ptr <= next_ptr;
        if (full) ovf   <= 1'b1;
        else      depth <= depth + DW'(1);
      end else if (do_pop) begin
        if (empty) begin
          unf <= 1'b1;
        end else begin
          top_ptr <= prev_ptr;
          depth   <= depth - DW'(1);
        end
      end else if (do_swap && empty) begin
        // BLR on an empty stack still leaves its return address behind
        top_ptr <= next_ptr;
        depth   <= DW'(1);
        unf     <= 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care after reset so no reset term
  always_ff @(posedge clk) begin
    if (do_push || (do_swap && empty)) stack[next_ptr] <= seq;
    else if (do_swap)                  stack[top_ptr]  <= seq;
  end

`ifdef NEXT_PC_TRACE_EN
  // Simulation trace of every non-sequential redirect and RAS fault
  always @(posedge clk) begin
    if (rst && !stall) begin
      if (PCinput != seq)
        $display("[next_pc_gen] pc=%h next=%h src=%s depth=%0d", count, PCinput,
                 ret ? "RET" : (link ? "BL" : (uncond_br ? "B" : "BCOND")), depth);
      if (do_push && full)
        $display("[next_pc_gen] warning: RAS overflow at pc=%h", count);
      if ((do_pop || do_swap) && empty)
        $display("[next_pc_gen] warning: RAS underflow at pc=%h", count);
    end
  end
`else
  // Trace disabled: no simulation-only statements are compiled
`endif

endmodule

`default_nettype wire
